// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetch unit: queue entry, FSM states and
// per-cycle control decisions.
package fetcher_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic redirect;
        logic misaligned;
        logic issue;
        logic push;
        logic pop;
    } control_info;

    function automatic logic is_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetched instructions; flush empties it and wins over push/pop.
module fetch_queue
    import fetcher_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetcher.sv
// Instruction fetch unit: issues sequential reads under a credit limit, queues the
// responses for decode, and follows redirects from execute.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              CLK,
    input  logic              RSTN,
    output logic              IMEM_EN,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [31:0]       IMEM_RDATA,
    output logic              INST_VALID,
    input  logic              INST_READY,
    output logic [31:0]       INST,
    output logic [31:0]       INST_PC,
    input  logic              REDIRECT_VALID,
    input  logic [31:0]       REDIRECT_PC,
    output logic              FETCH_FAULT
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       state;
    logic [31:0]        fetch_pc;
    logic               inflight;
    logic [31:0]        inflight_pc;
    logic               fetch_fault;
    control_info        ctl;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;
    logic [CNT_W-1:0]   count;
    logic [31:0]        occupancy;

    assign INST_VALID = (state == S_RUN) && (count != '0);

    always_comb begin
        ctl            = '0;
        ctl.redirect   = REDIRECT_VALID;
        ctl.misaligned = REDIRECT_VALID && !is_aligned(REDIRECT_PC[1:0]);
        ctl.pop        = INST_VALID && INST_READY && !REDIRECT_VALID;
        // A response is only worth keeping if no redirect lands in its return cycle.
        ctl.push       = inflight && !REDIRECT_VALID;
        occupancy      = 32'(count) + 32'(inflight) - 32'(ctl.pop);
        // RSTN gating keeps the read request low for as long as reset is held.
        ctl.issue      = RSTN && (state == S_RUN) && !REDIRECT_VALID
                         && (occupancy < 32'(DEPTH));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= S_RUN;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_fault <= 1'b0;
        end else begin
            inflight <= ctl.issue;
            if (ctl.issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            unique case (state)
                S_RUN: begin
                    if (ctl.redirect && ctl.misaligned) begin
                        state       <= S_FAULT;
                        fetch_fault <= 1'b1;
                    end
                end
                S_FAULT: begin
                    if (ctl.redirect && !ctl.misaligned) begin
                        state       <= S_RUN;
                        fetch_fault <= 1'b0;
                    end
                end
                default: state <= S_RUN;
            endcase
            if (ctl.redirect) begin
                fetch_pc <= REDIRECT_PC;
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = inflight_pc;
        push_entry.inst = IMEM_RDATA;
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .push       (ctl.push),
        .push_entry (push_entry),
        .pop        (ctl.pop),
        .flush      (ctl.redirect),
        .head       (head),
        .count      (count)
    );

    assign IMEM_EN     = ctl.issue;
    assign IMEM_ADDR   = fetch_pc[ADDR_W+1:2];
    assign INST        = head.inst;
    assign INST_PC     = head.pc;
    assign FETCH_FAULT = fetch_fault;

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: directed scenarios plus random back-pressure, all checked each
// cycle against a queue-based model of issued-but-undelivered fetches.
module tb_fetcher;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 2;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic              IMEM_EN;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [31:0]       IMEM_RDATA;
    logic              INST_VALID;
    logic              INST_READY;
    logic [31:0]       INST;
    logic [31:0]       INST_PC;
    logic              REDIRECT_VALID;
    logic [31:0]       REDIRECT_PC;
    logic              FETCH_FAULT;

    fetcher #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .IMEM_EN        (IMEM_EN),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_RDATA     (IMEM_RDATA),
        .INST_VALID     (INST_VALID),
        .INST_READY     (INST_READY),
        .INST           (INST),
        .INST_PC        (INST_PC),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .FETCH_FAULT    (FETCH_FAULT)
    );

    always #5 CLK = ~CLK;

    // Synchronous instruction memory: word k holds the value k.
    always @(posedge CLK) begin
        if (IMEM_EN) IMEM_RDATA <= 32'(IMEM_ADDR);
    end

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] issue_pc;
    bit          fault;
    int          cyc;
    int          tests;
    int          fails;
    int          dut_pops;
    int          dut_issues;
    logic [31:0] last_pop_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'(pc[ADDR_W+1:2]);
    endfunction

    // One clock cycle: apply inputs, compare against the model, then advance the model.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit exp_valid;
        bit exp_en;
        bit pop;
        int occ;
        INST_READY     = rdy;
        REDIRECT_VALID = redir;
        REDIRECT_PC    = rpc;
        #1;
        exp_valid = !fault && (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        pop       = exp_valid && rdy && !redir;
        occ       = q.size() - (pop ? 1 : 0);
        exp_en    = !fault && !redir && (occ < int'(DEPTH));
        chk("imem_en", 32'(IMEM_EN), 32'(exp_en));
        if (exp_en) chk("imem_addr", 32'(IMEM_ADDR), 32'(issue_pc[ADDR_W+1:2]));
        chk("inst_valid", 32'(INST_VALID), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_pc", INST_PC, q[0].pc);
            chk("inst", INST, mem_word(q[0].pc));
        end
        chk("fetch_fault", 32'(FETCH_FAULT), 32'(fault));
        if (IMEM_EN === 1'b1) dut_issues++;
        if (INST_VALID === 1'b1 && rdy && !redir) begin
            dut_pops++;
            last_pop_pc = INST_PC;
        end
        if (redir) begin
            q.delete();
            issue_pc = rpc;
            fault    = (rpc[1:0] != 2'b00);
        end else begin
            if (pop) void'(q.pop_front());
            if (exp_en) begin
                q.push_back('{pc: issue_pc, cyc: cyc});
                issue_pc = issue_pc + 32'd4;
            end
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN           = 1'b0;
        INST_READY     = 1'b0;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = '0;
        #1;
        chk("rst_imem_en", 32'(IMEM_EN), 32'd0);
        chk("rst_inst_valid", 32'(INST_VALID), 32'd0);
        chk("rst_inst", INST, 32'd0);
        chk("rst_inst_pc", INST_PC, 32'd0);
        chk("rst_fetch_fault", 32'(FETCH_FAULT), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        q.delete();
        issue_pc = 32'h0;
        fault    = 1'b0;
        cyc      = 0;
        RSTN     = 1'b1;
    endtask

    initial begin
        int start;
        tests       = 0;
        fails       = 0;
        dut_pops    = 0;
        dut_issues  = 0;
        last_pop_pc = '0;
        RSTN        = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // Start-up: deliveries of PC 0,4,8,12 in cycles 2..5.
        start = dut_pops;
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        chk("startup_pops", 32'(dut_pops - start), 32'd4);
        chk("startup_last_pc", last_pop_pc, 32'd12);

        // Back-pressure: queue fills to DEPTH, head held, no further reads.
        start = dut_issues;
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_head_pc", INST_PC, 32'd16);
        chk("stall_head_inst", INST, 32'd4);
        chk("stall_imem_en", 32'(IMEM_EN), 32'd0);
        chk("stall_issues", 32'(dut_issues - start), 32'd0);
        start = dut_pops;
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        chk("release_pops", 32'(dut_pops - start), 32'd8);
        chk("release_last_pc", last_pop_pc, 32'd44);

        // Aligned redirect with a read outstanding.
        cycle(1'b0, 1'b1, 32'h40);
        chk("redir_valid_drop", 32'(INST_VALID), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        start = dut_pops;
        for (int i = 0; i < 10 && dut_pops == start; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("redir_delivered", 32'(dut_pops - start), 32'd1);
        chk("redir_first_pc", last_pop_pc, 32'h40);

        // Misaligned redirect parks the unit until an aligned one arrives.
        cycle(1'b1, 1'b1, 32'h22);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        chk("fault_sticky", 32'(FETCH_FAULT), 32'd1);
        cycle(1'b1, 1'b1, 32'h0);
        chk("fault_cleared", 32'(FETCH_FAULT), 32'd0);
        start = dut_pops;
        for (int i = 0; i < 10 && dut_pops == start; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("resume_delivered", 32'(dut_pops - start), 32'd1);
        chk("resume_first_pc", last_pop_pc, 32'h0);

        // Reset while the queue holds entries.
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        chk("prerst_valid", 32'(INST_VALID), 32'd1);
        chk("prerst_imem_en", 32'(IMEM_EN), 32'd0);
        do_reset();
        start = dut_pops;
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        chk("restart_pops", 32'(dut_pops - start), 32'd4);
        chk("restart_last_pc", last_pop_pc, 32'd12);

        // Random consumer back-pressure.
        start = dut_pops;
        for (int i = 0; i < 1000; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        chk("random_progress", 32'(dut_pops - start > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 The block SHALL use one clock, CLK, and an asynchronous active-low reset, RSTN; no other clock or reset SHALL exist.
REQ-002 Parameter ADDR_W, default 6: word-address width of the instruction memory.
REQ-003 Parameter DEPTH, default 2: prefetch queue entries (power of two, >=2).
REQ-004 Parameter RESET_PC, default 32'h0: first fetch byte address.
REQ-005 CLK  input  1  clock, all state on rising edge.
REQ-006 RSTN  input  1  asynchronous active-low reset.
REQ-007 IMEM_EN  output  1  read request to instruction memory this cycle.
REQ-008 IMEM_ADDR  output  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
REQ-009 IMEM_RDATA  input  32  read data, valid exactly one cycle after IMEM_EN.
REQ-010 INST_VALID  output  1  queue head holds an instruction.
REQ-011 INST_READY  input  1  consumer (decode stage) accepts head.
REQ-012 INST  output  32  head instruction word.
REQ-013 INST_PC  output  32  byte address of head instruction.
REQ-014 REDIRECT_VALID  input  1  one-cycle pulse from execute: change flow.
REQ-015 REDIRECT_PC  input  32  new fetch byte address.
REQ-016 FETCH_FAULT  output  1  sticky: misaligned redirect received.

Function
REQ-017 FSM states SHALL be S_RUN and S_FAULT; reset enters S_RUN.
REQ-018 Pop SHALL occur when INST_VALID and INST_READY are both 1 in a cycle; INST/INST_PC SHALL hold stable while INST_VALID=1 and INST_READY=0.
REQ-019 In S_RUN, IMEM_EN SHALL be 1 when REDIRECT_VALID=0 and (count + inflight - pop) < DEPTH; fetch_pc SHALL then advance by 4 (32-bit wrap).
REQ-020 A response SHALL be pushed, tagged with its issue PC, in the cycle after issue unless a redirect occurred in the issue or response cycle.
REQ-021 Push and pop in the same cycle SHALL both take effect; the credit rule of REQ-019 SHALL make overflow impossible.
REQ-022 Fetch-to-INST_VALID latency SHALL be 2 cycles from an empty queue (issue cycle N, push N+1, INST_VALID at N+2).
REQ-023 Redirect with REDIRECT_PC[1:0]==0: the queue SHALL be flushed, any in-flight response discarded, fetch_pc set to REDIRECT_PC, and the first new IMEM_EN asserted in the next cycle; a same-cycle pop SHALL be ignored.
REQ-024 Redirect with REDIRECT_PC[1:0]!=0: flush as REQ-023, set FETCH_FAULT=1, enter S_FAULT.
REQ-025 In S_FAULT, IMEM_EN SHALL be 0 and INST_VALID 0; only an aligned redirect SHALL return to S_RUN and clear FETCH_FAULT.
REQ-026 Redirect has priority over issue, push and pop in the same cycle.

Reset
REQ-027 On RSTN=0: fetch_pc=RESET_PC, queue empty, inflight=0, IMEM_EN=0, INST_VALID=0, INST=0, INST_PC=0, FETCH_FAULT=0, state S_RUN.
REQ-028 Reset asserted mid-operation SHALL discard queue contents and in-flight data; the first IMEM_EN SHALL occur in the first cycle after RSTN deasserts.

Structure
REQ-029 fetch_entry_t (pc, inst) and the fetch state enum SHALL reside in the shared def package alongside control_info.
REQ-030 The queue SHALL be a sub-module fetch_queue (parameter DEPTH, push/pop/flush, count output), instantiated once.

Verification
REQ-031 Reset release, memory word k = k, INST_READY=1 -> IMEM_EN at cycle 0, INST_VALID at cycle 2 with INST_PC=0, then PC 4, 8, 12 on consecutive cycles.
REQ-032 INST_READY=0 for 10 cycles -> exactly DEPTH entries queued, IMEM_EN=0 after fill, INST stable; on release, entries in order, no loss or duplication.
REQ-033 Redirect to 32'h40 while queue full and a read in flight -> INST_VALID=0 next cycle, next IMEM_ADDR=16, first delivered INST_PC=32'h40.
REQ-034 Redirect to 32'h22 -> FETCH_FAULT=1, no IMEM_EN; later redirect to 32'h0 -> FETCH_FAULT=0, fetch resumes at 0.
REQ-035 RSTN pulsed low while queue holds 2 entries -> outputs at reset values immediately; restart at RESET_PC.
REQ-036 Random INST_READY for 1000 cycles against reference PC model -> INST_PC strictly sequential, INST equals memory word.
